// File: rtl/up_down_counter_n.sv
// up_down_counter_n: modulo-MODULUS up/down counter with combinational terminal count and registered wrap pulse.
// Parallel load is present only when UP_DOWN_COUNTER_N_LOAD_EN is defined; otherwise LD and D are ignored.
module up_down_counter_n #(
  parameter int              WIDTH   = 3,
  parameter longint unsigned MODULUS = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             EN,
  input  logic             Up_Down,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] q_next;
  logic             co_next;
  always_comb begin
    count_next = Up_Down ? ((Q == MAX) ? '0 : Q + ONE) : ((Q == '0) ? MAX : Q - ONE);
    TC         = EN & (Up_Down ? (Q == MAX) : (Q == '0));
  end
`ifdef UP_DOWN_COUNTER_N_LOAD_EN
  // Out-of-range load values saturate so Q never leaves 0..MODULUS-1; loads never signal a wrap.
  always_comb begin
    q_next  = LD ? ((D > MAX) ? MAX : D) : (EN ? count_next : Q);
    co_next = ~LD & TC;
  end
`else
  logic unused_load;
  assign unused_load = ^{LD, D};
  always_comb begin
    q_next  = EN ? count_next : Q;
    co_next = TC;
  end
`endif
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      Q  <= '0;
      CO <= 1'b0;
    end else begin
      Q  <= q_next;
      CO <= co_next;
    end
  end
endmodule

// File: tb/tb_up_down_counter_n.sv
// tb_up_down_counter_n: directed bench for up_down_counter_n (WIDTH=4, MODULUS=10) with a modulo-arithmetic reference model.
module tb_up_down_counter_n;
  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       EN = 1'b0;
  logic       Up_Down = 1'b0;
  logic       LD = 1'b0;
  logic [3:0] D = '0;
  logic [3:0] Q;
  logic       TC;
  logic       CO;
  int n_pass = 0;
  int n_total = 0;
  int q_m = 0;
  int co_m = 0;

  up_down_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
    .CP(CP), .CR(CR), .EN(EN), .Up_Down(Up_Down), .LD(LD), .D(D), .Q(Q), .TC(TC), .CO(CO)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CP);
    #2;
  endtask

  // Reference model: plain modulo-10 arithmetic on the sampled inputs.
  always @(posedge CP or posedge CR) begin
    if (CR) begin
      q_m = 0;
      co_m = 0;
    end else begin
`ifdef UP_DOWN_COUNTER_N_LOAD_EN
      if (LD) begin
        q_m = (int'(D) > 9) ? 9 : int'(D);
        co_m = 0;
      end else
`endif
      if (EN) begin
        co_m = Up_Down ? int'(q_m == 9) : int'(q_m == 0);
        q_m = Up_Down ? (q_m + 1) % 10 : (q_m + 9) % 10;
      end else co_m = 0;
    end
  end

  always @(negedge CP) begin
    check("model_q", int'(Q), q_m);
    check("model_co", int'(CO), co_m);
    check("model_tc", int'(TC), int'(EN && (Up_Down ? (q_m == 9) : (q_m == 0))));
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_q", int'(Q), 0);
    check("rst_co", int'(CO), 0);
    CR = 1'b0;
    EN = 1'b1;
    Up_Down = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("up_q", int'(Q), i % 10);
      check("up_co", int'(CO), int'(i == 10));
      check("up_tc", int'(TC), int'((i % 10) == 9));
    end
    Up_Down = 1'b0;
    tick();
    check("down_q0", int'(Q), 0);
    check("down_co0", int'(CO), 0);
    check("down_tc0", int'(TC), 1);
    tick();
    check("down_q9", int'(Q), 9);
    check("down_co9", int'(CO), 1);
    tick();
    check("down_q8", int'(Q), 8);
    check("down_co8", int'(CO), 0);
    Up_Down = 1'b1;
    repeat (5) tick();
    check("flip_q3", int'(Q), 3);
    Up_Down = 1'b0;
    tick();
    check("flip_q2", int'(Q), 2);
    EN = 1'b0;
    repeat (3) tick();
    check("hold_q", int'(Q), 2);
    check("hold_co", int'(CO), 0);
    check("hold_tc", int'(TC), 0);
    EN = 1'b1;
    LD = 1'b1;
    D = 4'd5;
    Up_Down = 1'b1;
`ifdef UP_DOWN_COUNTER_N_LOAD_EN
    tick();
    check("load_q5", int'(Q), 5);
    check("load_co5", int'(CO), 0);
    D = 4'd14;
    tick();
    check("load_sat", int'(Q), 9);
    D = 4'd9;
    tick();
    check("load_q9", int'(Q), 9);
    check("load_co9", int'(CO), 0);
`else
    tick();
    check("noload_q", int'(Q), 3);
    check("noload_co", int'(CO), 0);
`endif
    LD = 1'b0;
    CR = 1'b1;
    #1;
    check("arst_q", int'(Q), 0);
    CR = 1'b0;
    Up_Down = 1'b0;
    tick();
    check("pre_q9", int'(Q), 9);
    check("pre_co", int'(CO), 1);
    CR = 1'b1;
    #1;
    check("arst_q9", int'(Q), 0);
    check("arst_co", int'(CO), 0);
    #1;
    CR = 1'b0;
    Up_Down = 1'b1;
    tick();
    check("resume_q", int'(Q), 1);
    check("resume_co", int'(CO), 0);
    @(negedge CP);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/up_down_counter_n.md
UP_DOWN_COUNTER_N -- requirements
Module: up_down_counter_n

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 8: count sequence length; legal range 2..2^WIDTH; count range 0..MODULUS-1.
REQ-003 The block SHALL provide a port CP, input, 1 bit: the single clock; all state changes occur on its rising edge except reset.
REQ-004 The block SHALL provide a port CR, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL provide a port EN, input, 1 bit: count enable.
REQ-006 The block SHALL provide a port Up_Down, input, 1 bit: direction; 1 = count up, 0 = count down.
REQ-007 The block SHALL provide a port LD, input, 1 bit: synchronous parallel-load strobe.
REQ-008 The block SHALL provide a port D, input, WIDTH bits: parallel-load value.
REQ-009 The block SHALL provide a port Q, output, WIDTH bits: registered count value.
REQ-010 The block SHALL provide a port TC, output, 1 bit: combinational terminal-count flag.
REQ-011 The block SHALL provide a port CO, output, 1 bit: registered carry/borrow pulse.

Function
REQ-012 When LD=1 at a rising CP edge, the block SHALL load D into Q; LD SHALL take priority over EN.
REQ-013 When LD=1 and D > MODULUS-1, the block SHALL load MODULUS-1 into Q.
REQ-014 When LD=0 and EN=1 with Up_Down=1, Q SHALL become Q+1, wrapping from MODULUS-1 to 0.
REQ-015 When LD=0 and EN=1 with Up_Down=0, Q SHALL become Q-1, wrapping from 0 to MODULUS-1.
REQ-016 When LD=0 and EN=0, Q SHALL hold its value.
REQ-017 A change of Up_Down SHALL take effect at the very next enabled edge, with no extra cycle and no skipped value.
REQ-018 TC SHALL equal EN AND ((Up_Down=1 AND Q=MODULUS-1) OR (Up_Down=0 AND Q=0)).
REQ-019 CO SHALL be 1 for exactly the one cycle following an edge on which a counting wrap occurred (per REQ-014/REQ-015); otherwise CO SHALL be 0.
REQ-020 A load SHALL never assert CO, even when the loaded value equals a wrap target.
REQ-021 Count latency SHALL be one edge: Q SHALL update at the same edge that samples EN, LD and Up_Down.
REQ-022 When MODULUS = 2^WIDTH, wrap SHALL be the natural binary overflow/underflow, with identical TC and CO behaviour.
REQ-023 Q SHALL never hold a value greater than MODULUS-1 after reset.

Reset
REQ-024 While CR=1, the block SHALL force Q=0 and CO=0 immediately, independent of CP.
REQ-025 CR asserted mid-count or mid-load SHALL abort the operation; no pending CO pulse SHALL survive reset.
REQ-026 On the first rising CP edge after CR deasserts, the block SHALL resume normal operation using the inputs sampled at that edge.

Configuration
REQ-027 The parallel-load feature SHALL be controlled by the macro UP_DOWN_COUNTER_N_LOAD_EN.
REQ-028 With UP_DOWN_COUNTER_N_LOAD_EN defined, LD and D SHALL behave per REQ-012, REQ-013 and REQ-020.
REQ-029 With UP_DOWN_COUNTER_N_LOAD_EN undefined, LD and D SHALL still exist as ports but SHALL be ignored, the block SHALL contain no load logic, and the block SHALL behave as if LD=0 at all times.
REQ-030 All other behaviour SHALL be identical with and without UP_DOWN_COUNTER_N_LOAD_EN.

Verification
REQ-031 Wrap-up test (WIDTH=4, MODULUS=10): reset, then EN=1, Up_Down=1 for 11 edges -> Q runs 1..9, 0, 1; TC=1 while Q=9; CO=1 only in the cycle where Q=0.
REQ-032 Wrap-down test (WIDTH=4, MODULUS=10): from Q=0, EN=1, Up_Down=0 for 2 edges -> Q=9, then 8; TC=1 at Q=0 before the first edge; CO=1 for one cycle while Q=9.
REQ-033 Load test (macro defined, WIDTH=4, MODULUS=10): LD=1, EN=1, D=5 -> Q=5 with CO=0; then LD=1, D=14 -> Q=9; then LD=1, D=9 with Up_Down=1 -> Q=9 with CO=0.
REQ-034 Load-disabled test (macro undefined, WIDTH=4, MODULUS=10): LD=1, D=5, EN=1, Up_Down=1 from Q=2 -> Q=3.
REQ-035 Direction-flip test (WIDTH=4, MODULUS=10): Q=3 up, flip Up_Down to 0 before the next edge -> Q=2; hold with EN=0 for 3 edges -> Q=2.
REQ-036 Async reset test (WIDTH=4, MODULUS=10): pulse CR between clock edges when Q=9 with CO=1 -> Q=0 and CO=0 immediately; first edge after release with up-count enabled -> Q=1.
